mux_arb_stream: RTL and testbench

- N-channel, WIDTH-bit streaming multiplexer; the registered, handshaked successor to the combinational muxNto1 family.
- Selection comes from an internal arbiter (fixed priority or round-robin), not from a select input.
- Packets from one channel are never interleaved with another; one output register stage.
- Used to merge several producer streams (e.g. counter/ALU result streams) onto one consumer bus.

---
 rtl/mux_pkg.sv | 21 ++
 rtl/arb_grant_rr.sv | 35 +++
 rtl/mux_arb_stream.sv | 119 +++++++++++
 tb/tb_mux_arb_stream.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the arbitrated stream multiplexer: mode constants,
// lock state encoding and the index-width helper.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // Width needed to index n items, never less than 1.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/arb_grant_rr.sv
// Combinational arbiter: one-hot grant to the first request at or after ptr
// (round-robin) or to the lowest-index request (fixed priority).
module arb_grant_rr
    import mux_pkg::*;
#(
    parameter int N = 4,
    localparam int SEL_W = clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             mode,
    output logic [N-1:0]     gnt,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] base;
    logic [N-1:0]     req_rot;
    logic [N-1:0]     pick;

    // Rotate the doubled request vector so the search origin sits at bit 0,
    // isolate the lowest set bit, then rotate the pick back into place.
    assign base    = (mode == MODE_RR) ? ptr : '0;
    assign req_rot = N'({req, req} >> base);
    assign pick    = req_rot & (~req_rot + N'(1));
    assign gnt     = N'(({pick, pick} << base) >> N);

    always_comb begin
        // NOTE: default assignment first, so no path leaves idx unassigned and no latch is inferred.
        idx = '0;
        for (int k = 0; k < N; k++) begin
            if (gnt[k]) idx = SEL_W'(k);
        end
    end

endmodule

// File: rtl/mux_arb_stream.sv
// N-channel registered stream multiplexer with internal arbitration and
// packet locking; one output register stage, full throughput.
module mux_arb_stream
    import mux_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 32,
    localparam int SEL_W = clog2(N)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_mode,
    input  logic [N-1:0]         i_valid,
    output logic [N-1:0]         o_ready,
    input  logic [N*WIDTH-1:0]   i_data,
    input  logic [N-1:0]         i_last,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [WIDTH-1:0]     o_data,
    output logic [SEL_W-1:0]     o_sel,
    output logic                 o_last
);

    state_t           state;
    state_t           state_nxt;
    logic [SEL_W-1:0] lock_idx;
    logic             lock_mode;
    logic [SEL_W-1:0] ptr;

    logic [N-1:0]     arb_gnt;
    logic [SEL_W-1:0] arb_idx;
    logic [N-1:0]     gnt;
    logic [SEL_W-1:0] gnt_idx;
    logic             ld;
    logic             accept;
    logic             eff_mode;
    logic [WIDTH-1:0] sel_data;
    logic             sel_last;
    logic [SEL_W-1:0] ptr_next;

    arb_grant_rr #(.N(N)) u_arb (
        .req  (i_valid),
        .ptr  (ptr),
        .mode (i_mode),
        .gnt  (arb_gnt),
        .idx  (arb_idx)
    );

    assign ld       = ~o_valid | i_ready;
    assign accept   = |(i_valid & o_ready);
    // The mode that governs the packet in flight: live in IDLE, frozen while locked.
    assign eff_mode = (state == ST_IDLE) ? i_mode : lock_mode;
    assign ptr_next = (gnt_idx == SEL_W'(N - 1)) ? '0 : gnt_idx + SEL_W'(1);

    // State register, lock bookkeeping and round-robin pointer.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (i_rst) begin
            state     <= ST_IDLE;
            lock_idx  <= '0;
            lock_mode <= MODE_FIXED;
            ptr       <= '0;
        end else begin
            state <= state_nxt;
            if (accept && state == ST_IDLE) begin
                lock_idx  <= gnt_idx;
                lock_mode <= i_mode;
            end
            if (accept && sel_last && eff_mode == MODE_RR) ptr <= ptr_next;
        end
    end

    always_comb begin
        state_nxt = state;
        if (accept) state_nxt = sel_last ? ST_IDLE : ST_LOCKED;
    end

    // Grant and per-channel ready.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        if (state == ST_LOCKED) begin
            gnt     = N'(1) << lock_idx;
            gnt_idx = lock_idx;
        end else begin
            gnt     = arb_gnt;
            gnt_idx = arb_idx;
        end
        o_ready = gnt & {N{ld & ~i_rst}};
    end

    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int k = 0; k < N; k++) begin
            sel_data = sel_data | (i_data[k*WIDTH +: WIDTH] & {WIDTH{gnt[k]}});
            sel_last = sel_last | (i_last[k] & gnt[k]);
        end
    end

    // Output register: load on accept, drop valid when drained without a refill.
    always_ff @(posedge i_clk) begin
        // NOTE: reset is synchronous, and the data path is cleared too so o_data reads 0 after reset.
        if (i_rst) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_sel   <= '0;
            o_last  <= 1'b0;
        end else if (accept) begin
            o_valid <= 1'b1;
            o_data  <= sel_data;
            o_sel   <= gnt_idx;
            o_last  <= sel_last;
        end else if (i_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_arb_stream.sv
// Directed bench for mux_arb_stream: stimulus pushes expected beats into a
// scoreboard queue, a negedge monitor pops and compares on each output transfer.
module tb_mux_arb_stream;
    import mux_pkg::*;

    localparam int N     = 4;
    localparam int WIDTH = 32;
    localparam int SEL_W = 2;

    logic               i_clk = 1'b0;
    logic               i_rst;
    logic               i_mode;
    logic [N-1:0]       i_valid;
    logic [N-1:0]       o_ready;
    logic [N*WIDTH-1:0] i_data;
    logic [N-1:0]       i_last;
    logic               o_valid;
    logic               i_ready;
    logic [WIDTH-1:0]   o_data;
    logic [SEL_W-1:0]   o_sel;
    logic               o_last;

    logic [2:0] u_req;
    logic [1:0] u_ptr;
    logic       u_mode;
    logic [2:0] u_gnt;
    logic [1:0] u_idx;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SEL_W-1:0] sel;
        logic             last;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_exp;
    int    checks = 0;
    int    errors = 0;

    mux_arb_stream #(.N(N), .WIDTH(WIDTH)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_mode  (i_mode),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .i_last  (i_last),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_sel   (o_sel),
        .o_last  (o_last)
    );

    arb_grant_rr #(.N(3)) u_arb3 (
        .req  (u_req),
        .ptr  (u_ptr),
        .mode (u_mode),
        .gnt  (u_gnt),
        .idx  (u_idx)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_ch(input int k, input logic v, input logic [WIDTH-1:0] d, input logic l);
        i_valid[k]                 = v;
        i_data[k*WIDTH +: WIDTH]   = d;
        i_last[k]                  = l;
    endtask

    task automatic push_exp(input logic [WIDTH-1:0] d, input logic [SEL_W-1:0] s, input logic l);
        beat_t b;
        b.data = d;
        b.sel  = s;
        b.last = l;
        exp_q.push_back(b);
    endtask

    // Run until every expected beat has left and the output register is empty.
    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || o_valid) && n < 20) begin
            cyc();
            n++;
        end
        check({name, "_drained"}, 64'({exp_q.size(), o_valid}), 64'h0);
    endtask

    always @(negedge i_clk) begin
        if (!i_rst && o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got data %0h sel %0d last %0b, expected no beat",
                         o_data, o_sel, o_last);
            end else begin
                mon_exp = exp_q.pop_front();
                check("beat", 64'({o_data, o_sel, o_last}), 64'(mon_exp));
            end
        end
    end

    // Standalone arbiter vectors, N=3 (non power of two): {mode, ptr, req, gnt, idx}.
    logic [10:0] arb_vec [5] = '{
        {1'b1, 2'd2, 3'b011, 3'b001, 2'd0},
        {1'b1, 2'd1, 3'b101, 3'b100, 2'd2},
        {1'b0, 2'd2, 3'b110, 3'b010, 2'd1},
        {1'b1, 2'd0, 3'b000, 3'b000, 2'd0},
        {1'b1, 2'd2, 3'b100, 3'b100, 2'd2}
    };

    initial begin
        for (int v = 0; v < 5; v++) begin
            {u_mode, u_ptr, u_req} = arb_vec[v][10:5];
            #1;
            check($sformatf("arb3_vec%0d", v), 64'({u_gnt, u_idx}), 64'(arb_vec[v][4:0]));
        end

        // Reset: all channels requesting, yet nothing may be readied.
        i_rst   = 1'b1;
        i_mode  = MODE_FIXED;
        i_valid = '1;
        i_data  = '0;
        i_last  = '1;
        i_ready = 1'b1;
        cyc();
        #1;
        check("rst_ready", 64'(o_ready), 64'h0);
        check("rst_outputs", 64'({o_valid, o_last, o_sel, o_data}), 64'h0);
        check("rst_ptr", 64'(dut.ptr), 64'h0);
        cyc();
        check("rst_ready2", 64'(o_ready), 64'h0);

        // Single beat from channel 2.
        i_rst   = 1'b0;
        i_valid = '0;
        set_ch(2, 1'b1, 32'hA5A5_0002, 1'b1);
        push_exp(32'hA5A5_0002, 2'd2, 1'b1);
        #1;
        check("single_ready", 64'(o_ready), 64'h4);
        cyc();
        i_valid = '0;
        drain("single");

        // Round-robin fairness: all channels valid, single-beat packets.
        i_mode = MODE_RR;
        for (int k = 0; k < N; k++) set_ch(k, 1'b1, 32'hC000_0000 | k, 1'b1);
        for (int i = 0; i < 6; i++) begin
            push_exp(32'hC000_0000 | (i % 4), SEL_W'(i % 4), 1'b1);
            #1;
            check($sformatf("rr_ready%0d", i), 64'(o_ready), 64'(1 << (i % 4)));
            cyc();
        end
        i_valid = '0;
        drain("rr");
        check("rr_ptr", 64'(dut.ptr), 64'h2);

        // Fixed priority: channel 1 always beats channel 3.
        i_mode = MODE_FIXED;
        set_ch(1, 1'b1, 32'hB000_0001, 1'b1);
        set_ch(3, 1'b1, 32'hB000_0003, 1'b1);
        for (int i = 0; i < 4; i++) begin
            push_exp(32'hB000_0001, 2'd1, 1'b1);
            #1;
            check($sformatf("fixed_ready%0d", i), 64'(o_ready), 64'h2);
            cyc();
        end
        i_valid = '0;
        drain("fixed");
        check("fixed_ptr_held", 64'(dut.ptr), 64'h2);

        // Packet lock: channel 0 sends three beats while channel 1 waits.
        i_mode = MODE_RR;
        set_ch(1, 1'b1, 32'hD100_0001, 1'b1);
        for (int i = 0; i < 3; i++) begin
            set_ch(0, 1'b1, 32'hD000_0001 + i, i == 2);
            push_exp(32'hD000_0001 + i, 2'd0, i == 2);
            #1;
            check($sformatf("lock_ready%0d", i), 64'(o_ready), 64'h1);
            if (i == 1) check("lock_state", 64'(dut.state), 64'(ST_LOCKED));
            cyc();
        end
        set_ch(0, 1'b0, 32'h0, 1'b0);
        check("lock_ptr_after", 64'(dut.ptr), 64'h1);
        check("lock_released", 64'(dut.state), 64'(ST_IDLE));
        push_exp(32'hD100_0001, 2'd1, 1'b1);
        #1;
        check("lock_next_ready", 64'(o_ready), 64'h2);
        cyc();
        i_valid = '0;
        drain("lock");

        // Backpressure: held output stays stable, then refills with no bubble.
        i_mode = MODE_FIXED;
        set_ch(0, 1'b1, 32'hE000_0000, 1'b1);
        push_exp(32'hE000_0000, 2'd0, 1'b1);
        #1;
        check("bp_first_ready", 64'(o_ready), 64'h1);
        cyc();
        i_ready = 1'b0;
        set_ch(0, 1'b1, 32'hE000_0001, 1'b1);
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("bp_ready%0d", i), 64'(o_ready), 64'h0);
            check($sformatf("bp_hold%0d", i), 64'({o_valid, o_last, o_sel, o_data}),
                  64'({1'b1, 1'b1, 2'd0, 32'hE000_0000}));
            cyc();
        end
        i_ready = 1'b1;
        push_exp(32'hE000_0001, 2'd0, 1'b1);
        #1;
        check("bp_release_ready", 64'(o_ready), 64'h1);
        cyc();
        i_valid = '0;
        check("bp_no_bubble", 64'({o_valid, o_data}), 64'({1'b1, 32'hE000_0001}));
        drain("bp");

        // Reset mid-packet: lock on channel 2, reset, channel 0 must then win.
        i_mode = MODE_RR;
        set_ch(2, 1'b1, 32'hF200_0000, 1'b0);
        #1;
        check("mid_lock_ready", 64'(o_ready), 64'h4);
        cyc();
        check("mid_locked", 64'(dut.state), 64'(ST_LOCKED));
        i_rst   = 1'b1;
        i_ready = 1'b0;
        i_valid = '0;
        set_ch(0, 1'b1, 32'h0F00_0000, 1'b1);
        #1;
        check("mid_rst_ready", 64'(o_ready), 64'h0);
        cyc();
        i_rst = 1'b0;
        check("mid_rst_clear", 64'({o_valid, dut.ptr, dut.state}), 64'({1'b0, 2'd0, ST_IDLE}));
        set_ch(2, 1'b1, 32'hF200_0001, 1'b1);
        i_ready = 1'b1;
        push_exp(32'h0F00_0000, 2'd0, 1'b1);
        #1;
        check("mid_after_ready", 64'(o_ready), 64'h1);
        cyc();
        i_valid = '0;
        drain("mid");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
